// File: rtl/branch_execute_cycle_if.sv
// Decode-to-execute control-flow bundle plus the execute/memory results it produces.
// Modports: master = decode/hazard side, slave = branch resolver.
interface branch_execute_cycle_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic             ValidD;
   logic             BranchD;
   logic             JumpD;
   logic             JalrD;
   logic [2:0]       Funct3D;
   logic [XLEN-1:0]  RD1D;
   logic [XLEN-1:0]  RD2D;
   logic [XLEN-1:0]  ImmExtD;
   logic [XLEN-1:0]  PCD;
   logic [XLEN-1:0]  PCPlus4D;
   logic [4:0]       RdD;

   logic             PCSrcE;
   logic [XLEN-1:0]  PCTargetE;
   logic             FlushD;
   logic             FlushE;
   logic             MisalignE;
   logic             IllegalBrE;
   logic             RegWriteM;
   logic [4:0]       RdM;
   logic [XLEN-1:0]  LinkM;
   logic [CNT_W-1:0] RedirectCount;

   modport master (
      output ValidD, BranchD, JumpD, JalrD, Funct3D, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, RdD,
      input  PCSrcE, PCTargetE, FlushD, FlushE, MisalignE, IllegalBrE,
      input  RegWriteM, RdM, LinkM, RedirectCount
   );

   modport slave (
      input  ValidD, BranchD, JumpD, JalrD, Funct3D, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, RdD,
      output PCSrcE, PCTargetE, FlushD, FlushE, MisalignE, IllegalBrE,
      output RegWriteM, RdM, LinkM, RedirectCount
   );
endinterface

// File: rtl/branch_execute_cycle.sv
// Execute-stage branch/jump resolver: D/E register in, redirect out combinationally from D/E state,
// link write registered into E/M one edge later; no backpressure, a redirect squashes F/D and D/E.
module branch_execute_cycle #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   branch_execute_cycle_if.slave  bus
);

   typedef struct packed {
      logic            valid;
      logic            branch;
      logic            jump;
      logic            jalr;
      logic [2:0]      funct3;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] immExt;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pcPlus4;
      logic [4:0]      rd;
   } deReg_t;

   deReg_t           deNext;
   deReg_t           deE;

   logic             condMet;
   logic             illegalFn;
   logic [XLEN-1:0]  sumPc;
   logic [XLEN-1:0]  sumReg;
   logic [XLEN-1:0]  targetE;
   logic             takenE;
   logic             misalignE;
   logic             pcSrcE;
   logic             linkWr;

   logic             regWriteM;
   logic [4:0]       rdM;
   logic [XLEN-1:0]  linkM;
   logic [CNT_W-1:0] redirectCount;

   always_comb begin
      deNext         = '0;
      deNext.valid   = bus.ValidD;
      deNext.branch  = bus.BranchD;
      deNext.jump    = bus.JumpD;
      deNext.jalr    = bus.JalrD;
      deNext.funct3  = bus.Funct3D;
      deNext.rd1     = bus.RD1D;
      deNext.rd2     = bus.RD2D;
      deNext.immExt  = bus.ImmExtD;
      deNext.pc      = bus.PCD;
      deNext.pcPlus4 = bus.PCPlus4D;
      deNext.rd      = bus.RdD;
   end

   // A redirect turns whatever decode offers this edge into a bubble.
   always_ff @(posedge clk) begin
      if (rst || pcSrcE) begin
         deE <= '0;
      end else begin
         deE <= deNext;
      end
   end

   always_comb begin
      condMet   = 1'b0;
      illegalFn = 1'b0;
      case (deE.funct3)
         3'b000:  condMet = (deE.rd1 == deE.rd2);
         3'b001:  condMet = (deE.rd1 != deE.rd2);
         3'b100:  condMet = ($signed(deE.rd1) <  $signed(deE.rd2));
         3'b101:  condMet = ($signed(deE.rd1) >= $signed(deE.rd2));
         3'b110:  condMet = (deE.rd1 <  deE.rd2);
         3'b111:  condMet = (deE.rd1 >= deE.rd2);
         default: illegalFn = 1'b1;
      endcase
   end

   assign sumPc   = deE.pc  + deE.immExt;
   assign sumReg  = deE.rd1 + deE.immExt;
   assign targetE = deE.jalr ? {sumReg[XLEN-1:1], 1'b0} : sumPc;

   assign takenE    = deE.valid & (deE.jump | deE.jalr | (deE.branch & condMet));
   assign misalignE = takenE & (targetE[1:0] != 2'b00);
   assign pcSrcE    = takenE & ~misalignE;
   assign linkWr    = deE.valid & (deE.jump | deE.jalr) & (deE.rd != 5'd0) & ~misalignE;

   always_ff @(posedge clk) begin
      if (rst) begin
         regWriteM     <= 1'b0;
         rdM           <= 5'd0;
         linkM         <= '0;
         redirectCount <= '0;
      end else begin
         regWriteM <= linkWr;
         rdM       <= linkWr ? deE.rd      : 5'd0;
         linkM     <= linkWr ? deE.pcPlus4 : '0;
         if (pcSrcE) begin
            redirectCount <= redirectCount + 1'b1;
         end
      end
   end

   assign bus.PCSrcE        = pcSrcE;
   assign bus.PCTargetE     = deE.valid ? targetE : '0;
   assign bus.FlushD        = pcSrcE;
   assign bus.FlushE        = pcSrcE;
   assign bus.MisalignE     = misalignE;
   assign bus.IllegalBrE    = deE.valid & deE.branch & illegalFn;
   assign bus.RegWriteM     = regWriteM;
   assign bus.RdM           = rdM;
   assign bus.LinkM         = linkM;
   assign bus.RedirectCount = redirectCount;

endmodule

// File: tb/tb_branch_execute_cycle.sv
// Directed vectors for the execute-stage branch resolver; counter is narrowed so its wrap is reachable.
module tb_branch_execute_cycle;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;

   logic clk;
   logic rst;
   int   vecCount;
   int   missCount;

   branch_execute_cycle_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

   branch_execute_cycle #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecCount++;
      if (got !== exp) begin
         missCount++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic setD(input logic v, input logic b, input logic j, input logic jr,
                       input logic [2:0] f3, input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
      bus.ValidD   = v;
      bus.BranchD  = b;
      bus.JumpD    = j;
      bus.JalrD    = jr;
      bus.Funct3D  = f3;
      bus.RD1D     = rd1;
      bus.RD2D     = rd2;
      bus.ImmExtD  = imm;
      bus.PCD      = pc;
      bus.PCPlus4D = pc + 32'd4;
      bus.RdD      = rd;
   endtask

   task automatic setIdle();
      setD(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecCount  = 0;
      missCount = 0;

      // Reset held with a valid JAL offered
      rst = 1'b1;
      setD(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'h20, 32'h100, 5'd3);
      step();
      step();
      checkVal("rst_pcsrc",   bus.PCSrcE, 0);
      checkVal("rst_target",  bus.PCTargetE, 0);
      checkVal("rst_count",   bus.RedirectCount, 0);
      checkVal("rst_regwr",   bus.RegWriteM, 0);
      checkVal("rst_flushd",  bus.FlushD, 0);
      rst = 1'b0;
      setIdle();
      step();
      checkVal("idle_pcsrc",  bus.PCSrcE, 0);
      checkVal("idle_count",  bus.RedirectCount, 0);
      checkVal("idle_regwr",  bus.RegWriteM, 0);

      // BEQ taken
      setD(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'd5, 32'd5, 32'h20, 32'h100, 5'd0);
      step();
      checkVal("beq_t_pcsrc",  bus.PCSrcE, 1);
      checkVal("beq_t_target", bus.PCTargetE, 32'h120);
      checkVal("beq_t_flushd", bus.FlushD, 1);
      checkVal("beq_t_flushe", bus.FlushE, 1);
      checkVal("beq_t_cnt0",   bus.RedirectCount, 0);
      setIdle();
      step();
      checkVal("beq_t_cnt1",   bus.RedirectCount, 1);
      checkVal("beq_t_after",  bus.PCSrcE, 0);
      checkVal("beq_t_regwr",  bus.RegWriteM, 0);

      // BEQ not taken
      setD(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'd5, 32'd6, 32'h20, 32'h100, 5'd0);
      step();
      checkVal("beq_n_pcsrc",  bus.PCSrcE, 0);
      checkVal("beq_n_target", bus.PCTargetE, 32'h120);
      setIdle();
      step();
      checkVal("beq_n_cnt",    bus.RedirectCount, 1);

      // Signed vs unsigned compare of -1 against 1
      setD(1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd0);
      step();
      checkVal("blt_pcsrc",    bus.PCSrcE, 1);
      setIdle();
      step();
      checkVal("blt_cnt",      bus.RedirectCount, 2);
      setD(1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd0);
      step();
      checkVal("bltu_pcsrc",   bus.PCSrcE, 0);
      checkVal("bltu_illegal", bus.IllegalBrE, 0);
      setD(1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd0);
      step();
      checkVal("b010_illegal", bus.IllegalBrE, 1);
      checkVal("b010_pcsrc",   bus.PCSrcE, 0);
      setIdle();
      step();
      checkVal("b010_clear",   bus.IllegalBrE, 0);
      checkVal("b010_cnt",     bus.RedirectCount, 2);

      // Non-valid slot with jump fields set
      setD(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'h20, 32'h100, 5'd4);
      step();
      checkVal("inv_pcsrc",    bus.PCSrcE, 0);
      checkVal("inv_target",   bus.PCTargetE, 0);
      setIdle();
      step();
      checkVal("inv_regwr",    bus.RegWriteM, 0);

      // JALR misaligned target
      setD(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'h2003, 32'd0, 32'h4, 32'h204, 5'd1);
      step();
      checkVal("jalr_m_target", bus.PCTargetE, 32'h2006);
      checkVal("jalr_m_mis",    bus.MisalignE, 1);
      checkVal("jalr_m_pcsrc",  bus.PCSrcE, 0);
      setIdle();
      step();
      checkVal("jalr_m_regwr",  bus.RegWriteM, 0);
      checkVal("jalr_m_link",   bus.LinkM, 0);

      // JALR aligned with link
      setD(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'h2000, 32'd0, 32'h4, 32'h204, 5'd1);
      step();
      checkVal("jalr_target",  bus.PCTargetE, 32'h2004);
      checkVal("jalr_pcsrc",   bus.PCSrcE, 1);
      checkVal("jalr_mis",     bus.MisalignE, 0);
      setIdle();
      step();
      checkVal("jalr_regwr",   bus.RegWriteM, 1);
      checkVal("jalr_rdm",     bus.RdM, 1);
      checkVal("jalr_link",    bus.LinkM, 32'h208);
      checkVal("jalr_cnt",     bus.RedirectCount, 3);

      // Back-to-back JALs: second one is flushed
      setD(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'h40, 32'h300, 5'd2);
      step();
      checkVal("b2b_pcsrc1",   bus.PCSrcE, 1);
      checkVal("b2b_target1",  bus.PCTargetE, 32'h340);
      setD(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'h80, 32'h340, 5'd5);
      step();
      checkVal("b2b_pcsrc2",   bus.PCSrcE, 0);
      checkVal("b2b_target2",  bus.PCTargetE, 0);
      checkVal("b2b_cnt",      bus.RedirectCount, 4);
      checkVal("b2b_regwr",    bus.RegWriteM, 1);
      checkVal("b2b_rdm",      bus.RdM, 2);
      checkVal("b2b_link",     bus.LinkM, 32'h304);
      setIdle();
      step();
      checkVal("b2b_cnt_hold", bus.RedirectCount, 4);
      checkVal("b2b_bub_wr",   bus.RegWriteM, 0);

      // JAL to x0 never links
      setD(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'h8, 32'h400, 5'd0);
      step();
      checkVal("jal0_pcsrc",   bus.PCSrcE, 1);
      setIdle();
      step();
      checkVal("jal0_regwr",   bus.RegWriteM, 0);
      checkVal("jal0_rdm",     bus.RdM, 0);
      checkVal("jal0_cnt",     bus.RedirectCount, 5);

      // Target wrap-around
      setD(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'h20, 32'hFFFF_FFF0, 5'd0);
      step();
      checkVal("wrap_target",  bus.PCTargetE, 32'h10);
      checkVal("wrap_pcsrc",   bus.PCSrcE, 1);
      setIdle();
      step();
      checkVal("wrap_cnt",     bus.RedirectCount, 6);

      // Drive the 4-bit counter to all-ones, then over the top
      for (int i = 0; i < 9; i++) begin
         setD(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'h10, 32'h0, 5'd0);
         step();
         setIdle();
         step();
      end
      checkVal("cnt_full",     bus.RedirectCount, 32'hF);
      setD(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'h10, 32'h0, 5'd0);
      step();
      setIdle();
      step();
      checkVal("cnt_wrap",     bus.RedirectCount, 0);

      // Reset while a redirect is in E
      setD(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'h10, 32'h500, 5'd7);
      step();
      checkVal("rstmid_pcsrc", bus.PCSrcE, 1);
      rst = 1'b1;
      step();
      checkVal("rstmid_cnt",   bus.RedirectCount, 0);
      checkVal("rstmid_regwr", bus.RegWriteM, 0);
      checkVal("rstmid_link",  bus.LinkM, 0);
      checkVal("rstmid_drop",  bus.PCSrcE, 0);
      rst = 1'b0;
      setIdle();
      step();
      checkVal("rstmid_idle",  bus.RedirectCount, 0);
      checkVal("rstmid_tgt",   bus.PCTargetE, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
